siren_audio_out: RTL and testbench

Output stage downstream of the `ambulance` siren generator. It takes the generator's 1-bit `speaker` square wave and converts it into an amplitude-enveloped PWM stream for the board's mono audio amplifier. Volume ramps up smoothly on start and down on stop (attack/sustain/release), so the siren does not click, and the block drives the amplifier shutdown pin.

---
 rtl/siren_audio_out.sv | 119 +++++++++++
 tb/tb_siren_audio_out.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/siren_audio_out.sv
// Siren output stage: synchronizes the speaker square wave and emits an
// attack/sustain/release enveloped PWM stream plus amplifier enable.
module siren_audio_out #(
    parameter int PWM_BITS        = 8,
    parameter int ENV_STEP_CYCLES = 390625
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                speaker_in,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] volume,
    output logic                aud_pwm,
    output logic                aud_sd,
    output logic                active,
    output logic [PWM_BITS-1:0] env_level,
    output logic [1:0]          state_o
);

    localparam int PRE_W = (ENV_STEP_CYCLES > 2) ? $clog2(ENV_STEP_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                spk_meta_q, spk_s_q;
    logic                aud_pwm_q, aud_pwm_d;
    logic                active_q, active_d;
    logic [PWM_BITS-1:0] duty;
    logic                tick;

    always_comb begin
        tick      = (state_q != S_IDLE) && (presc_q == PRE_LAST);
        presc_d   = '0;
        if (state_q != S_IDLE) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        duty      = spk_s_q ? level_q : '0;
        aud_pwm_d = (pwm_cnt_q < duty);
        active_d  = (state_q != S_IDLE);
    end

    // Level only moves on tick and only toward its bound, so it can never wrap.
    always_comb begin
        level_d = level_q;
        case (state_q)
            S_ATTACK: begin
                if (tick && (level_q < volume)) level_d = level_q + 1'b1;
            end
            S_SUSTAIN: begin
                if (tick && (level_q < volume)) level_d = level_q + 1'b1;
                else if (tick && (level_q > volume)) level_d = level_q - 1'b1;
            end
            S_RELEASE: begin
                if (tick && (level_q != '0)) level_d = level_q - 1'b1;
            end
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ATTACK;
            end
            S_ATTACK: begin
                if (!enable) state_d = S_RELEASE;
                else if (level_q >= volume) state_d = S_SUSTAIN;
            end
            S_SUSTAIN: begin
                if (!enable) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Leave on the same edge the level lands on zero so status drops one cycle later.
                if (enable) state_d = S_ATTACK;
                else if (level_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            level_q    <= '0;
            spk_meta_q <= 1'b0;
            spk_s_q    <= 1'b0;
            aud_pwm_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            level_q    <= level_d;
            spk_meta_q <= speaker_in;
            spk_s_q    <= spk_meta_q;
            aud_pwm_q  <= aud_pwm_d;
            active_q   <= active_d;
        end
    end

    assign aud_pwm   = aud_pwm_q;
    assign aud_sd    = active_q;
    assign active    = active_q;
    assign env_level = level_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_siren_audio_out.sv
// Directed bench for siren_audio_out with a 4-bit PWM and 4-cycle envelope step.
module tb_siren_audio_out;

    localparam int W    = 4;
    localparam int STEP = 4;

    logic         clk;
    logic         rst_n;
    logic         speaker_in;
    logic         enable;
    logic [W-1:0] volume;
    logic         aud_pwm;
    logic         aud_sd;
    logic         active;
    logic [W-1:0] env_level;
    logic [1:0]   state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int e0       = 0;
    logic [W-1:0] exp_q[$];

    siren_audio_out #(.PWM_BITS(W), .ENV_STEP_CYCLES(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .speaker_in(speaker_in),
        .enable    (enable),
        .volume    (volume),
        .aud_pwm   (aud_pwm),
        .aud_sd    (aud_sd),
        .active    (active),
        .env_level (env_level),
        .state_o   (state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // cyc - e0 is 0 mod STEP right after an envelope tick edge
    task automatic align(input int phase);
        while (((cyc - e0) % STEP) != phase) step(1);
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step(1);
            hi += int'(aud_pwm);
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    initial begin : main
        int hi;
        int prev;
        int bad;
        int d;

        rst_n      = 1'b0;
        speaker_in = 1'b0;
        enable     = 1'b0;
        volume     = '0;
        step(2);
        check("rst_pwm", aud_pwm, 0);
        check("rst_sd", aud_sd, 0);
        check("rst_active", active, 0);
        check("rst_level", env_level, 0);
        check("rst_state", state_o, 0);
        rst_n = 1'b1;
        step(3);
        check("idle_state", state_o, 0);

        // attack 0 -> 8
        volume = 4'd8;
        enable = 1'b1;
        step(1);
        e0 = cyc;
        for (int c = 0; c <= 33; c++) exp_q.push_back(W'((c / 4 > 8) ? 8 : c / 4));
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) step(1);
            check("attack_level", env_level, int'(exp_q.pop_front()));
            check("attack_state", state_o, (c <= 32) ? 1 : 2);
            check("attack_sd", aud_sd, (c >= 1) ? 1 : 0);
        end
        step(8);
        check("sustain_hold", env_level, 8);

        // PWM duty and speaker latency
        speaker_in = 1'b1;
        step(3);
        count_high(16, hi);
        check("duty_l8", hi, 8);
        speaker_in = 1'b0;
        step(2);
        count_high(16, hi);
        check("spk_off", hi, 0);

        // release 8 -> 5, re-attack to 8
        align(0);
        enable = 1'b0;
        step(1);
        for (int j = 0; j <= 11; j++) begin
            if (j > 0) step(1);
            check("rel_level", env_level, 8 - (j + 1) / 4);
            check("rel_state", state_o, 3);
        end
        enable = 1'b1;
        step(1);
        for (int j = 0; j <= 12; j++) begin
            if (j > 0) step(1);
            check("reatk_level", env_level, (5 + (j + 1) / 4 > 8) ? 8 : 5 + (j + 1) / 4);
            check("reatk_state", state_o, (j <= 11) ? 1 : 2);
        end

        // full release to idle
        align(1);
        enable = 1'b0;
        step(1);
        for (int j = 0; j <= 31; j++) begin
            if (j > 0) step(1);
            check("fall_level", env_level, (j < 2) ? 8 : ((8 - (j + 2) / 4 < 0) ? 0 : 8 - (j + 2) / 4));
            check("fall_state", state_o, (j < 30) ? 3 : 0);
            check("fall_active", active, (j <= 30) ? 1 : 0);
            check("fall_sd", aud_sd, (j <= 30) ? 1 : 0);
        end

        // volume tracking 8 -> 3 -> 0
        speaker_in = 1'b1;
        enable     = 1'b1;
        step(1);
        e0 = cyc;
        step(33);
        check("trk_start_level", env_level, 8);
        check("trk_start_state", state_o, 2);
        align(0);
        volume = 4'd3;
        step(1);
        for (int j = 0; j <= 19; j++) begin
            if (j > 0) step(1);
            check("trk_down_level", env_level, 8 - (j + 1) / 4);
        end
        count_high(16, hi);
        check("duty_l3", hi, 3);
        check("trk_hold3", env_level, 3);
        volume = 4'd0;
        step(1);
        for (int j = 0; j <= 11; j++) begin
            if (j > 0) step(1);
            check("vol0_level", env_level, 3 - (j + 1) / 4);
            check("vol0_sd", aud_sd, 1);
        end
        count_high(20, hi);
        check("vol0_pwm", hi, 0);
        check("vol0_sd_end", aud_sd, 1);
        check("vol0_state", state_o, 2);
        check("vol0_level_end", env_level, 0);

        // saturation at 15 and toggling between extremes
        volume = 4'd15;
        prev   = int'(env_level);
        bad    = 0;
        repeat (70) begin
            step(1);
            if (int'(env_level) < prev) bad++;
            prev = int'(env_level);
        end
        check("sat_up_monotonic", bad, 0);
        check("sat_level", env_level, 15);
        count_high(16, hi);
        check("duty_l15", hi, 15);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if ((i % 10) == 0) volume = ((i / 10) % 2 == 1) ? 4'd15 : 4'd0;
            step(1);
            d = int'(env_level) - prev;
            if (d > 1 || d < -1) bad++;
            prev = int'(env_level);
        end
        check("sat_toggle_step", bad, 0);
        volume = 4'd0;
        bad    = 0;
        repeat (70) begin
            step(1);
            if (int'(env_level) > prev) bad++;
            prev = int'(env_level);
        end
        check("sat_down_monotonic", bad, 0);
        check("sat_floor", env_level, 0);

        // asynchronous reset in sustain
        volume = 4'd8;
        step(70);
        check("pre_rst_level", env_level, 8);
        check("pre_rst_state", state_o, 2);
        rst_n  = 1'b0;
        enable = 1'b0;
        #2;
        check("async_pwm", aud_pwm, 0);
        check("async_sd", aud_sd, 0);
        check("async_active", active, 0);
        check("async_level", env_level, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_state", state_o, 0);
        check("post_rst_active", active, 0);
        check("post_rst_level", env_level, 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
